// File: rtl/nios_tdma_pkg.sv
// rtl/nios_tdma_pkg.sv - shared constants and types for the TDMA transmit slave
package nios_tdma_pkg;

    localparam logic [1:0] REG_DEST   = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_SLOT   = 2'd3;

    localparam int STATUS_FULL_BIT  = 0;
    localparam int STATUS_EMPTY_BIT = 1;
    localparam int STATUS_OVF_BIT   = 2;
    localparam int STATUS_COUNT_LSB = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tdma_state_t;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } tx_word_t;

endpackage

// File: rtl/nios_tdma_fifo.sv
// rtl/nios_tdma_fifo.sv - synchronous FIFO with full/empty/count, sync active-high reset
module nios_tdma_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy; pointers wrap naturally (DEPTH is a power of two)
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while empty, so no reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/nios_tdma_send.sv
// rtl/nios_tdma_send.sv - Avalon-MM slave queuing TDMA words and sending them in the own slot
module nios_tdma_send
    import nios_tdma_pkg::*;
#(
    parameter int NODE_ID     = 0,
    parameter int NUM_SLOTS   = 8,
    parameter int SLOT_CYCLES = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   address,
    input  logic                         chipselect,
    input  logic                         write_n,
    input  logic [31:0]                  writedata,
    output logic [31:0]                  readdata,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic [7:0]                   tx_addr,
    output logic [31:0]                  tx_data,
    output logic [$clog2(NUM_SLOTS)-1:0] tx_slot
);

    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int CNT_W  = $clog2(SLOT_CYCLES);
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [SLOT_W-1:0] OWN_SLOT  = SLOT_W'(NODE_ID);

    tdma_state_t        state_q, state_d;
    logic [CNT_W-1:0]   slot_cnt_q, slot_cnt_d;
    logic [SLOT_W-1:0]  tx_slot_q, tx_slot_d;
    logic [7:0]         dest_q, dest_d;
    logic               ovf_q, ovf_d;
    logic               tx_valid_q, tx_valid_d;
    logic [7:0]         tx_addr_q, tx_addr_d;
    logic [31:0]        tx_data_q, tx_data_d;
    logic [31:0]        readdata_q, readdata_d;

    logic               bus_wr, push, pop, slot_wrap;
    logic               fifo_full, fifo_empty;
    logic [FCNT_W-1:0]  fifo_count;
    logic [39:0]        fifo_rdata;
    tx_word_t           push_word, head;
    logic [31:0]        status_word;

    assign push_word = '{addr: dest_q, data: writedata};
    assign head      = tx_word_t'(fifo_rdata);
    assign pop       = tx_valid_q & tx_ready;

    nios_tdma_fifo #(
        .WIDTH ($bits(tx_word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (push_word),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Register writes: DEST latch, FIFO push, sticky overflow (set beats clear)
    always_comb begin
        bus_wr = chipselect & ~write_n;
        push   = bus_wr && (address == REG_DATA) && !fifo_full;
        dest_d = (bus_wr && (address == REG_DEST)) ? writedata[7:0] : dest_q;
        ovf_d  = ovf_q;
        if (bus_wr && (address == REG_STATUS) && writedata[STATUS_OVF_BIT]) begin
            ovf_d = 1'b0;
        end
        if (bus_wr && (address == REG_DATA) && fifo_full) begin
            ovf_d = 1'b1;
        end
    end

    // Free-running slot timer
    always_comb begin
        slot_wrap  = (slot_cnt_q == LAST_CNT);
        slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + CNT_W'(1);
        tx_slot_d  = tx_slot_q;
        if (slot_wrap) begin
            tx_slot_d = (tx_slot_q == LAST_SLOT) ? '0 : tx_slot_q + SLOT_W'(1);
        end
    end

    // Send FSM: start at slot_cnt 0 of own slot, leave on handshake or at slot end
    always_comb begin
        state_d    = state_q;
        tx_valid_d = tx_valid_q;
        tx_addr_d  = tx_addr_q;
        tx_data_d  = tx_data_q;
        case (state_q)
            ST_IDLE: begin
                if ((tx_slot_q == OWN_SLOT) && (slot_cnt_q == '0) && !fifo_empty) begin
                    state_d    = ST_SEND;
                    tx_valid_d = 1'b1;
                    tx_addr_d  = head.addr;
                    tx_data_d  = head.data;
                end
            end
            ST_SEND: begin
                if (pop || slot_wrap) begin
                    state_d    = ST_IDLE;
                    tx_valid_d = 1'b0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    // Read mux, registered every cycle regardless of chipselect
    always_comb begin
        status_word                          = '0;
        status_word[STATUS_FULL_BIT]         = fifo_full;
        status_word[STATUS_EMPTY_BIT]        = fifo_empty;
        status_word[STATUS_OVF_BIT]          = ovf_q;
        status_word[31:STATUS_COUNT_LSB]     = 28'(fifo_count);
        case (address)
            REG_DEST:   readdata_d = {24'b0, dest_q};
            REG_DATA:   readdata_d = 32'b0;
            REG_STATUS: readdata_d = status_word;
            REG_SLOT:   readdata_d = {16'(slot_cnt_q), 16'(tx_slot_q)};
            default:    readdata_d = 32'b0;
        endcase
    end

    // All control and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            slot_cnt_q <= '0;
            tx_slot_q  <= '0;
            dest_q     <= '0;
            ovf_q      <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_addr_q  <= '0;
            tx_data_q  <= '0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            slot_cnt_q <= slot_cnt_d;
            tx_slot_q  <= tx_slot_d;
            dest_q     <= dest_d;
            ovf_q      <= ovf_d;
            tx_valid_q <= tx_valid_d;
            tx_addr_q  <= tx_addr_d;
            tx_data_q  <= tx_data_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign tx_valid = tx_valid_q;
    assign tx_addr  = tx_addr_q;
    assign tx_data  = tx_data_q;
    assign tx_slot  = tx_slot_q;

endmodule

// File: tb/tb_nios_tdma_send.sv
// tb/tb_nios_tdma_send.sv - self-checking bench for nios_tdma_send
module tb_nios_tdma_send;

    localparam int NODE = 2;
    localparam int NS   = 4;
    localparam int SC   = 8;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_addr;
    logic [31:0] tx_data;
    logic [1:0]  tx_slot;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [39:0] mq[$];
    bit          m_sending;
    logic [7:0]  m_dest;
    bit          m_ovf;
    int          m_t;
    logic [31:0] m_rd;

    nios_tdma_send #(
        .NODE_ID     (NODE),
        .NUM_SLOTS   (NS),
        .SLOT_CYCLES (SC),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_addr    (tx_addr),
        .tx_data    (tx_data),
        .tx_slot    (tx_slot)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, m_t);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        int v;
        case (a)
            2'd0: v = int'(m_dest);
            2'd1: v = 0;
            2'd2: v = mq.size() * 16 + (m_ovf ? 4 : 0) + (mq.size() == 0 ? 2 : 0)
                      + (mq.size() == DEPTH ? 1 : 0);
            default: v = (m_t % SC) * 65536 + (m_t / SC) % NS;
        endcase
        return 32'(v);
    endfunction

    task automatic model_edge();
        bit hs, was_full, was_nonempty, wr;
        int cnt, slot;
        if (reset === 1'b1) begin
            mq.delete();
            m_sending = 0;
            m_dest    = '0;
            m_ovf     = 0;
            m_t       = 0;
            m_rd      = '0;
            return;
        end
        m_rd         = model_read(address);
        hs           = m_sending && (tx_ready === 1'b1);
        was_full     = (mq.size() == DEPTH);
        was_nonempty = (mq.size() != 0);
        cnt          = m_t % SC;
        slot         = (m_t / SC) % NS;
        wr           = (chipselect === 1'b1) && (write_n === 1'b0);
        if (hs) void'(mq.pop_front());
        if (wr && address == 2'd2 && writedata[2]) m_ovf = 0;
        if (wr && address == 2'd1) begin
            if (was_full) m_ovf = 1;
            else mq.push_back({m_dest, writedata});
        end
        if (wr && address == 2'd0) m_dest = writedata[7:0];
        if (m_sending) m_sending = !(hs || cnt == SC - 1);
        else m_sending = (slot == NODE) && (cnt == 0) && was_nonempty;
        m_t++;
    endtask

    task automatic step();
        logic [39:0] h;
        @(posedge clk);
        model_edge();
        #1;
        chk("tx_valid", 64'(tx_valid), 64'(m_sending));
        chk("tx_slot", 64'(tx_slot), 64'((m_t / SC) % NS));
        chk("readdata", 64'(readdata), 64'(m_rd));
        if (m_sending && mq.size() > 0) begin
            h = mq[0];
            chk("tx_addr", 64'(tx_addr), 64'(h[39:32]));
            chk("tx_data", 64'(tx_data), 64'(h[31:0]));
        end
    endtask

    task automatic set_idle();
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = '0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        step();
        set_idle();
    endtask

    task automatic bus_read(input logic [1:0] a);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        step();
        set_idle();
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 4 * NS * SC && tx_valid !== 1'b1; i++) step();
        chk(name, 64'(tx_valid), 64'd1);
    endtask

    initial begin
        int rise_k, high_n, run, best;
        logic [7:0]  cap_addr;
        logic [31:0] cap_data;
        logic [31:0] sent[$];
        logic [31:0] exp_sent[4];

        // Reset state
        set_idle();
        reset = 1'b1;
        step();
        step();
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_tx_slot", 64'(tx_slot), 64'd0);
        chk("rst_readdata", 64'(readdata), 64'd0);
        reset = 1'b0;
        bus_read(2'd0); chk("rd_dest0", 64'(readdata), 64'h0);
        bus_read(2'd1); chk("rd_data0", 64'(readdata), 64'h0);
        bus_read(2'd2); chk("rd_status0", 64'(readdata), 64'h2);
        bus_read(2'd3); chk("rd_slot0", 64'(readdata), 64'h0003_0000);

        // Single word with tx_ready high
        bus_write(2'd0, 32'h05);
        bus_write(2'd1, 32'hDEADBEEF);
        tx_ready = 1'b1;
        rise_k = -1; high_n = 0; cap_addr = '0; cap_data = '0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (tx_valid === 1'b1) begin
                if (rise_k < 0) begin
                    rise_k = m_t; cap_addr = tx_addr; cap_data = tx_data;
                end
                high_n++;
            end
        end
        chk("first_rise_cycle", 64'(rise_k), 64'd17);
        chk("single_high_cycles", 64'(high_n), 64'd1);
        chk("single_addr", 64'(cap_addr), 64'h05);
        chk("single_data", 64'(cap_data), 64'hDEADBEEF);
        bus_read(2'd2); chk("rd_status_after_send", 64'(readdata), 64'h2);

        // Overflow, OVF clear, hold-off for a whole slot, then ordered drain
        tx_ready = 1'b0;
        bus_write(2'd0, 32'h0A);
        for (int i = 1; i <= 4; i++) bus_write(2'd1, 32'h11111111 * i);
        bus_read(2'd2); chk("rd_status_full", 64'(readdata), 64'h41);
        bus_write(2'd1, 32'h55555555);
        bus_read(2'd2); chk("rd_status_ovf", 64'(readdata), 64'h45);
        bus_write(2'd2, 32'h4);
        bus_read(2'd2); chk("rd_status_ovf_clr", 64'(readdata), 64'h41);
        run = 0; best = 0; cap_data = '0;
        for (int i = 0; i < NS * SC * 2; i++) begin
            step();
            if (tx_valid === 1'b1) begin
                run++;
                if (run == 1) cap_data = tx_data;
            end else run = 0;
            if (run > best) best = run;
        end
        chk("hold_high_cycles", 64'(best), 64'(SC - 1));
        chk("hold_head", 64'(cap_data), 64'h11111111);
        tx_ready = 1'b1;
        for (int i = 0; i < NS * SC * 4 + SC; i++) begin
            step();
            if (tx_valid === 1'b1) sent.push_back(tx_data);
        end
        exp_sent = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        chk("drain_count", 64'(sent.size()), 64'd4);
        for (int i = 0; i < 4 && i < sent.size(); i++) chk("drain_order", 64'(sent[i]), 64'(exp_sent[i]));
        bus_read(2'd2); chk("rd_status_drained", 64'(readdata), 64'h2);

        // Reset during SEND
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) bus_write(2'd1, 32'hC0DE0000 + i);
        wait_valid("wait_send_before_reset");
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("reset_drops_valid", 64'(tx_valid), 64'd0);
        bus_read(2'd2); chk("rd_status_after_reset", 64'(readdata), 64'h2);
        tx_ready = 1'b1;
        high_n = 0;
        for (int i = 0; i < NS * SC + SC * 2; i++) begin
            step();
            if (tx_valid === 1'b1) high_n++;
        end
        chk("no_send_after_reset", 64'(high_n), 64'd0);

        // Push during pop at count 3, then last-cycle handshake
        tx_ready = 1'b0;
        bus_write(2'd0, 32'h0C);
        for (int i = 1; i <= 3; i++) bus_write(2'd1, 32'hA0000000 + i);
        wait_valid("wait_send_pushpop");
        tx_ready = 1'b1;
        bus_write(2'd1, 32'hA0000004);
        tx_ready = 1'b0;
        bus_read(2'd2); chk("rd_status_pushpop", 64'(readdata), 64'h30);
        wait_valid("wait_send_last");
        for (int i = 0; i < SC && (m_t % SC) != SC - 1; i++) step();
        chk("last_cycle_valid", 64'(tx_valid), 64'd1);
        chk("last_cycle_head", 64'(tx_data), 64'hA0000002);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        bus_read(2'd2); chk("rd_status_last_pop", 64'(readdata), 64'h20);
        wait_valid("wait_send_next");
        chk("no_retry_head", 64'(tx_data), 64'hA0000003);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 599) == 0);
            chipselect = ($urandom_range(0, 1) == 1);
            write_n    = ($urandom_range(0, 2) == 0);
            address    = 2'($urandom_range(0, 3));
            writedata  = $urandom;
            tx_ready   = ($urandom_range(0, 3) != 0);
            step();
        end
        reset = 1'b0;
        set_idle();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nios_tdma_send.md
# nios_tdma_send

Avalon-MM slave on the Nios system bus that queues outgoing TDMA words (8-bit destination address plus 32-bit payload) written by software. It releases them onto the TDMA network interface only during this node's own time slot. It is the transmit counterpart of the node's receive-address/receive-data input ports. It sits between the Nios data master and the TDMA link transmitter.

## Interface
Parameters:
- NODE_ID, 0: slot index owned by this node (0..NUM_SLOTS-1)
- NUM_SLOTS, 8: slots per TDMA frame
- SLOT_CYCLES, 16: clock cycles per slot (≥2)
- FIFO_DEPTH, 4: queued words (power of two, ≥2)

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- address  in  2  Avalon register select
- chipselect  in  1  Avalon slave select
- write_n  in  1  active-low write strobe; write = chipselect & !write_n
- writedata  in  32  write data
- readdata  out  32  registered read data
- tx_valid  out  1  word presented on tx_addr/tx_data
- tx_ready  in  1  link accepts word when high with tx_valid
- tx_addr  out  8  destination node address
- tx_data  out  32  payload
- tx_slot  out  log2(NUM_SLOTS)  current slot index

## Operation
- Registers (address: write / read):
  - 0 DEST: writedata[7:0] latched / {24'b0, DEST}.
  - 1 DATA: push {DEST, writedata} into FIFO if not full; if full, drop and set OVF / 0.
  - 2 STATUS: write bit2=1 clears OVF / {count[27:0] at [31:4] zero-extended, 1'b0, OVF, empty, full} (bit0 full, bit1 empty, bit2 OVF, bits[7:4] count).
  - 3 SLOT: no effect / {slot_cnt in [31:16], tx_slot in [15:0]}.
- Slot timer: slot_cnt counts 0..SLOT_CYCLES-1 and then wraps. tx_slot increments on each slot_cnt wrap; it runs 0..NUM_SLOTS-1 and then wraps. The timer runs continuously.
- FSM IDLE/SEND:
  - IDLE→SEND at the edge where tx_slot==NODE_ID, slot_cnt==0, and FIFO is not empty.
  - SEND: tx_valid=1, tx_addr/tx_data = FIFO head.
  - SEND→IDLE on handshake (tx_valid&tx_ready). The head pops at the same edge.
  - SEND→IDLE at the edge where slot_cnt==SLOT_CYCLES-1 with no handshake. The head is retained and retried in the next own slot.
  - At most one word is sent per own slot.
- A handshake on the last slot cycle pops the word. It is not retained.
- Push when full is rejected even if a pop occurs in the same cycle; OVF is set. A simultaneous push and pop otherwise leaves count unchanged.
- OVF is sticky. If a clear-write and an overflowing push occur in the same cycle, the set wins.
- The FIFO head is stable while in SEND. Pushes never alter the head.

## Timing
- Reset (at the clock edge where reset=1), all outputs/state:
  - readdata=0, tx_valid=0, tx_addr=0, tx_data=0, tx_slot=0
  - slot_cnt=0, DEST=0, OVF=0, FIFO empty, FSM=IDLE
- Reset asserted during SEND drops tx_valid at that edge. The queued word is lost.
- readdata updates every clock from address (no read strobe). Read latency is 1 cycle.
- Register writes take effect at the write edge and are visible in readdata 2 cycles after the write cycle. There is no waitrequest.
- A push becomes eligible for transmission starting from the next slot_cnt==0 of the own slot.
- tx_valid first rises when slot_cnt==1 of the own slot. The latest handshake possible is at slot_cnt==SLOT_CYCLES-1.
- tx_addr/tx_data are held constant while tx_valid=1.

## Structure
- Package nios_tdma_pkg holds:
  - register address constants (REG_DEST=0, REG_DATA=1, REG_STATUS=2, REG_SLOT=3)
  - STATUS bit positions
  - FSM state enum
  - 40-bit tx word typedef {addr[7:0], data[31:0]}
- Sub-module nios_tdma_fifo: synchronous FIFO, parameterised width/depth, with full/empty/count outputs. Its reset is synchronous active-high.

## Test plan
- Reset, then read each address → readdata 0 everywhere except STATUS=0x2 (empty). tx_valid=0, tx_slot=0.
- NODE_ID=2: write DEST=0x05, DATA=0xDEADBEEF with tx_ready=1 → tx_valid high for exactly 1 cycle at tx_slot=2, slot_cnt=1, with tx_addr=0x05, tx_data=0xDEADBEEF. STATUS then reads empty.
- Hold tx_ready=0 for a whole own slot → tx_valid=1 for SLOT_CYCLES-1 cycles, then drops. The same word is re-presented in the next frame's own slot and is accepted when tx_ready=1.
- Push 5 words with FIFO_DEPTH=4 → STATUS=0x41 (count 4, full), then OVF set (0x45). Write STATUS bit2=1 → OVF clears. The 4 accepted words are sent in order, one per frame.
- Assert reset while tx_valid=1 with 3 words queued → tx_valid=0 and STATUS=0x2 after reset. No transmission occurs in the following frame.
- In the same cycle as a handshake pop, push while count=3 → push is accepted and count stays 3. A handshake on slot_cnt=SLOT_CYCLES-1 pops the word with no retry.
